// File: rtl/psum_drain_pkg.sv
// Shared constants and state encoding for the psum drain path.
package psum_drain_pkg;

  localparam int unsigned DW      = 40;            // psum width per channel
  localparam int unsigned AW      = 16;            // psum buffer address width
  localparam int unsigned TM      = 4;             // channels per entry
  localparam int unsigned OW      = 16;            // activation width
  localparam int unsigned FD      = 8;             // output FIFO depth
  localparam int unsigned CW      = $clog2(FD) + 1; // FIFO/credit counter width
  localparam int unsigned ALPHA_Q = 8;             // PReLU slope fraction bits
  localparam int unsigned SW      = DW + 1;        // biased sum width
  localparam int unsigned MW      = SW + OW;       // full PReLU product width
  localparam int unsigned PW      = MW - ALPHA_Q;  // post-PReLU width
  localparam int unsigned RW      = PW + 1;        // rounding headroom

  localparam logic signed [RW-1:0] SAT_HI = RW'((2 ** (OW - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_LO = -SAT_HI - RW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/psum_drain_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
module psum_drain_sync_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTW = $clog2(DEPTH);
  localparam int unsigned CTW = PTW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTW-1:0]   wp;
  logic [PTW-1:0]   rp;

  // Storage, pointers and count; push and pop may coincide at any level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= wp + PTW'(1);
      end
      if (pop) rp <= rp + PTW'(1);
      count <= count + CTW'(push) - CTW'(pop);
    end
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/psum_drain.sv
// Streams a psum tile out of the buffer: bias, PReLU, round/shift/saturate, pack.
module psum_drain
  import psum_drain_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [15:0]      tile_size,
  input  logic [5:0]       shift,
  input  logic             prelu_en,
  input  logic [TM*OW-1:0] bias,
  input  logic [TM*OW-1:0] alpha,
  output logic             re,
  output logic [AW-1:0]    ra,
  input  logic [TM*DW-1:0] rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TM*OW-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t         state;
  logic [AW-1:0]  base_q;
  logic [15:0]    size_q;
  logic [15:0]    idx;
  logic [5:0]     shift_q;
  logic           prelu_q;
  logic           re_last;
  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fifo_count;
  logic           rd_v, s1_v, s2_v, s3_v;
  logic           rd_l, s1_l, s2_l, s3_l;
  logic [CW:0]    credit_c;
  logic           issue_c;
  logic           pop_c;
  logic           flush_ok_c;
  logic [TM*OW:0] fifo_wdata;
  logic [TM*OW:0] fifo_rdata;

  assign credit_c   = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_c    = (state == DRAIN) && (credit_c < (CW + 1)'(FD));
  assign pop_c      = out_valid && out_ready;
  assign flush_ok_c = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop_c));

  // Control FSM: sampling, read issue, completion handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      base_q  <= '0;
      size_q  <= '0;
      idx     <= '0;
      shift_q <= '0;
      prelu_q <= 1'b0;
      re      <= 1'b0;
      ra      <= '0;
      re_last <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      re      <= 1'b0;
      ra      <= '0;
      re_last <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= DRAIN;
            busy    <= 1'b1;
            base_q  <= base_addr;
            size_q  <= tile_size;
            shift_q <= shift;
            prelu_q <= prelu_en;
            idx     <= '0;
          end
        end
        DRAIN: begin
          if (issue_c) begin
            re      <= 1'b1;
            ra      <= base_q + AW'(idx);
            re_last <= (idx == size_q);
            idx     <= idx + 16'd1;
            if (idx == size_q) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (flush_ok_c) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Valid/last shadow of the arithmetic pipeline and in-flight credit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {rd_v, s1_v, s2_v, s3_v} <= '0;
      {rd_l, s1_l, s2_l, s3_l} <= '0;
      inflight                 <= '0;
    end else begin
      rd_v     <= re;
      s1_v     <= rd_v;
      s2_v     <= s1_v;
      s3_v     <= s2_v;
      rd_l     <= re_last;
      s1_l     <= rd_l;
      s2_l     <= s1_l;
      s3_l     <= s2_l;
      inflight <= inflight + CW'(issue_c) - CW'(s3_v);
    end
  end

  for (genvar g = 0; g < int'(TM); g++) begin : g_ch
    logic signed [DW-1:0] psum_c;
    logic signed [OW-1:0] bias_c;
    logic signed [OW-1:0] alpha_c;
    logic signed [SW-1:0] sum_c, sum_q;
    logic signed [MW-1:0] prod_c;
    logic signed [PW-1:0] p_c, p_q;
    logic signed [RW-1:0] rnd_c, r_c, r_q;
    logic        [OW-1:0] act_c;

    assign psum_c  = rd[g*DW +: DW];
    assign bias_c  = bias[g*OW +: OW];
    assign alpha_c = alpha[g*OW +: OW];

    // Bias is pre-aligned to psum scale before adding
    assign sum_c  = SW'(psum_c) + (SW'(bias_c) <<< shift_q);
    assign prod_c = MW'(sum_q) * MW'(alpha_c);
    assign p_c    = (prelu_q && sum_q[SW-1]) ? PW'(prod_c >>> ALPHA_Q) : PW'(sum_q);
    assign rnd_c  = (shift_q == 6'd0) ? '0 : (RW'(1) << (shift_q - 6'd1));
    assign r_c    = (RW'(p_q) + rnd_c) >>> shift_q;
    assign act_c  = (r_q > SAT_HI) ? OW'(SAT_HI) :
                    (r_q < SAT_LO) ? OW'(SAT_LO) : OW'(r_q);

    assign fifo_wdata[g*OW +: OW] = act_c;

    // Three register stages: biased sum, PReLU, rounded shift
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        p_q   <= '0;
        r_q   <= '0;
      end else begin
        sum_q <= sum_c;
        p_q   <= p_c;
        r_q   <= r_c;
      end
    end
  end

  assign fifo_wdata[TM*OW] = s3_l;

  psum_drain_sync_fifo #(
    .WIDTH (TM * OW + 1),
    .DEPTH (FD)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s3_v),
    .wdata (fifo_wdata),
    .pop   (pop_c),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_rdata[TM*OW-1:0];
  assign out_last  = fifo_rdata[TM*OW];

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain with a behavioural psum buffer.
module tb_psum_drain;
  import psum_drain_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [15:0]      tile_size = '0;
  logic [5:0]       shift = '0;
  logic             prelu_en = 1'b0;
  logic [TM*OW-1:0] bias = '0;
  logic [TM*OW-1:0] alpha = '0;
  logic             re;
  logic [AW-1:0]    ra;
  logic [TM*DW-1:0] rd = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [TM*OW-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             done;

  psum_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .tile_size(tile_size), .shift(shift), .prelu_en(prelu_en),
    .bias(bias), .alpha(alpha), .re(re), .ra(ra), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [TM*DW-1:0] mem [0:65535];
  always @(posedge clk) rd <= re ? mem[ra] : '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = 0;
  int re_count = 0;
  int words_seen = 0;
  int rdy_mode = 0;
  bit mon_en = 1'b0;
  bit done_chk_next = 1'b0;
  logic [TM*OW-1:0] last_data = '0;
  logic             last_flag = 1'b0;

  logic [TM*OW:0] exp_q [$];
  logic [AW-1:0]  addr_q [$];

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OW-1:0] ref_act(input longint ps, input longint b, input longint a,
                                            input int sh, input bit pe);
    longint s, p, r;
    s = ps + b * (longint'(1) << sh);
    if (pe && s < 0) p = (s * a) >>> 8;
    else p = s;
    r = p + ((sh > 0) ? (longint'(1) << (sh - 1)) : longint'(0));
    r = r >>> sh;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [TM*OW-1:0] ref_word(input logic [AW-1:0] a, input logic [5:0] sh,
                                                input bit pe);
    logic [TM*OW-1:0] w;
    w = '0;
    for (int k = 0; k < int'(TM); k++) begin
      logic signed [DW-1:0] ps;
      logic signed [OW-1:0] b, al;
      ps = mem[a][k*DW +: DW];
      b  = bias[k*OW +: OW];
      al = alpha[k*OW +: OW];
      w[k*OW +: OW] = ref_act(ps, b, al, int'(sh), pe);
    end
    return w;
  endfunction

  task automatic set_ch(input logic [AW-1:0] a, input int k, input longint v);
    logic [TM*DW-1:0] t;
    t = mem[a];
    t[k*DW +: DW] = DW'(v);
    mem[a] = t;
  endtask

  task automatic launch(input logic [AW-1:0] base, input logic [15:0] ts,
                        input logic [5:0] sh, input bit pe);
    logic [AW-1:0] a;
    for (int i = 0; i <= int'(ts); i++) begin
      a = base + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back({(i == int'(ts)), ref_word(a, sh, pe)});
    end
    @(posedge clk); #1;
    base_addr = base; tile_size = ts; shift = sh; prelu_en = pe; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", 64'(n >= max), 64'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_re"}, 64'(re), 64'(0));
    check_eq({tag, "_ra"}, 64'(ra), 64'(0));
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(0));
    check_eq({tag, "_data"}, 64'(out_data), 64'(0));
    check_eq({tag, "_last"}, 64'(out_last), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // Consumer ready pattern
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: address order, word scoreboard, done/busy timing
  always @(negedge clk) begin
    if (mon_en) begin
      if (re) begin
        re_count++;
        if (addr_q.size() == 0) check_eq("re_extra", 64'(1), 64'(0));
        else check_eq("ra", 64'(ra), 64'(addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        logic [TM*OW:0] e;
        words_seen++;
        last_data = out_data;
        last_flag = out_last;
        if (exp_q.size() == 0) check_eq("word_extra", 64'(1), 64'(0));
        else begin
          e = exp_q.pop_front();
          check_eq("word_data", 64'(out_data), 64'(e[TM*OW-1:0]));
          check_eq("word_last", 64'(out_last), 64'(e[TM*OW]));
        end
        if (out_last) last_hs = cyc;
      end
      if (done_chk_next) begin
        check_eq("done_width", 64'(done), 64'(0));
        check_eq("busy_after_done", 64'(busy), 64'(0));
        done_chk_next = 1'b0;
      end
      if (done) begin
        check_eq("done_gap", 64'(cyc - last_hs), 64'(1));
        done_chk_next = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++)
      for (int k = 0; k < int'(TM); k++)
        set_ch(AW'(a), k, longint'({$urandom, $urandom}) <<< 24 >>> 24);

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Positive path
    bias  = {16'd0, 16'd0, 16'd0, 16'd2};
    alpha = {4{16'h0100}};
    mem[16'h0010] = '0;
    set_ch(16'h0010, 0, 1280);
    launch(16'h0010, 16'd0, 6'd8, 1'b1);
    wait_idle(100);
    check_eq("pos_ch0", 64'(last_data[15:0]), 64'(16'd7));
    check_eq("pos_last", 64'(last_flag), 64'(1));

    // PReLU on and off
    bias  = '0;
    alpha = {16'h0100, 16'h0100, 16'h0040, 16'h0100};
    mem[16'h0020] = '0;
    set_ch(16'h0020, 1, -2560);
    launch(16'h0020, 16'd0, 6'd8, 1'b1);
    wait_idle(100);
    check_eq("prelu_ch1", 64'(last_data[31:16]), 64'(16'hFFFE));
    launch(16'h0020, 16'd0, 6'd8, 1'b0);
    wait_idle(100);
    check_eq("ident_ch1", 64'(last_data[31:16]), 64'(16'hFFF6));

    // Saturation and zero shift
    mem[16'h0030] = '0;
    set_ch(16'h0030, 0, 5);
    set_ch(16'h0030, 2, longint'(1) << 30);
    set_ch(16'h0030, 3, -(longint'(1) << 30));
    launch(16'h0030, 16'd0, 6'd4, 1'b0);
    wait_idle(100);
    check_eq("sat_hi", 64'(last_data[47:32]), 64'(16'h7FFF));
    check_eq("sat_lo", 64'(last_data[63:48]), 64'(16'h8000));
    launch(16'h0030, 16'd0, 6'd0, 1'b0);
    wait_idle(100);
    check_eq("shift0_ch0", 64'(last_data[15:0]), 64'(16'd5));

    // Backpressure with address wrap
    bias  = {$urandom, $urandom};
    alpha = {$urandom, $urandom};
    rdy_mode = 2;
    re_count = 0;
    words_seen = 0;
    launch(16'hFFFE, 16'd9, 6'd12, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("bp_reads", 64'(re_count), 64'(8));
    check_eq("bp_valid", 64'(out_valid), 64'(1));
    rdy_mode = 0;
    wait_idle(300);
    check_eq("bp_words", 64'(words_seen), 64'(10));

    // Random ready over a long tile
    rdy_mode = 1;
    words_seen = 0;
    launch(16'h1000, 16'd63, 6'd12, 1'b1);
    wait_idle(3000);
    check_eq("rand_words", 64'(words_seen), 64'(64));
    rdy_mode = 0;

    // Abort during drain, then a normal run
    launch(16'h2000, 16'd63, 6'd10, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("abort_pre_busy", 64'(busy), 64'(1));
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort");
    exp_q.delete();
    addr_q.delete();
    done_chk_next = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    words_seen = 0;
    launch(16'h2000, 16'd5, 6'd10, 1'b0);
    wait_idle(300);
    check_eq("post_abort_words", 64'(words_seen), 64'(6));

    // Start while busy is ignored
    words_seen = 0;
    launch(16'h3000, 16'd15, 6'd8, 1'b1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    base_addr = 16'h5000; tile_size = 16'd2; shift = 6'd3; prelu_en = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(300);
    check_eq("ignore_words", 64'(words_seen), 64'(16));

    repeat (5) @(negedge clk);
    check_eq("final_idle_busy", 64'(busy), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
